// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_WIDTH_DEFAULT = 4;
    localparam int unsigned REG_IDX_W         = 5;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        rob_type_e            typ;
        logic [REG_IDX_W-1:0] rd;
        logic                 pred_taken;
        logic [31:0]          alt_pc;
        logic [31:0]          val;
    } rob_entry_t;

    // Branch outcome travels in bit 0 of the broadcast value.
    function automatic logic branch_mispredicted(input logic taken, input logic pred_taken);
        return taken != pred_taken;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus between the core (master) and the reorder buffer (slave): issue, result
// broadcasts, operand queries, commit and flush.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
);
    logic                 readyIn;
    logic                 issueFlag;
    logic [1:0]           issueType;
    logic [REG_IDX_W-1:0] issueRd;
    logic                 issuePredTaken;
    logic [31:0]          issueAltPc;
    logic [ROB_WIDTH-1:0] issueTag;
    logic                 full;
    logic                 aluFlag;
    logic [31:0]          aluVal;
    logic [ROB_WIDTH-1:0] aluDest;
    logic                 lsbFlag;
    logic [31:0]          lsbVal;
    logic [ROB_WIDTH-1:0] lsbDest;
    logic [ROB_WIDTH-1:0] queryJ;
    logic                 queryJReady;
    logic [31:0]          queryJVal;
    logic [ROB_WIDTH-1:0] queryK;
    logic                 queryKReady;
    logic [31:0]          queryKVal;
    logic                 commitFlag;
    logic [REG_IDX_W-1:0] commitRd;
    logic [31:0]          commitVal;
    logic [ROB_WIDTH-1:0] commitTag;
    logic                 commitStore;
    logic                 flushFlag;
    logic [31:0]          flushPc;

    modport master (
        output readyIn, issueFlag, issueType, issueRd, issuePredTaken, issueAltPc,
        output aluFlag, aluVal, aluDest, lsbFlag, lsbVal, lsbDest, queryJ, queryK,
        input  issueTag, full, queryJReady, queryJVal, queryKReady, queryKVal,
        input  commitFlag, commitRd, commitVal, commitTag, commitStore, flushFlag, flushPc
    );

    modport slave (
        input  readyIn, issueFlag, issueType, issueRd, issuePredTaken, issueAltPc,
        input  aluFlag, aluVal, aluDest, lsbFlag, lsbVal, lsbDest, queryJ, queryK,
        output issueTag, full, queryJReady, queryJVal, queryKReady, queryKVal,
        output commitFlag, commitRd, commitVal, commitTag, commitStore, flushFlag, flushPc
    );
endinterface

// File: rtl/rob_query_port.sv
// Operand-tag lookup into the ROB. Optional macro ROB_QUERY_BYPASS_EN adds a
// same-cycle match against the ALU/LSB broadcasts (ALU has priority).
module rob_query_port
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic [ROB_WIDTH-1:0]              tag_i,
    input  logic [(2**ROB_WIDTH)-1:0]         busy_i,
    input  logic [(2**ROB_WIDTH)-1:0]         ready_i,
    input  logic [(2**ROB_WIDTH)-1:0][31:0]   val_i,
    input  logic                              alu_flag_i,
    input  logic [31:0]                       alu_val_i,
    input  logic [ROB_WIDTH-1:0]              alu_dest_i,
    input  logic                              lsb_flag_i,
    input  logic [31:0]                       lsb_val_i,
    input  logic [ROB_WIDTH-1:0]              lsb_dest_i,
    output logic                              ready_o,
    output logic [31:0]                       val_o
);
    logic        lookup_ready;
    logic [31:0] lookup_val;

    // Registered-state lookup; a non-busy entry never reports ready.
    always_comb begin
        lookup_ready = busy_i[tag_i] && ready_i[tag_i];
        lookup_val   = val_i[tag_i];
    end

`ifdef ROB_QUERY_BYPASS_EN
    // Forward a result broadcast in the same cycle it appears.
    always_comb begin
        ready_o = lookup_ready;
        val_o   = lookup_val;
        if (alu_flag_i && (alu_dest_i == tag_i)) begin
            ready_o = 1'b1;
            val_o   = alu_val_i;
        end else if (lsb_flag_i && (lsb_dest_i == tag_i)) begin
            ready_o = 1'b1;
            val_o   = lsb_val_i;
        end
    end
`else
    assign ready_o = lookup_ready;
    assign val_o   = lookup_val;

    logic unused_bypass;
    assign unused_bypass = ^{alu_flag_i, alu_val_i, alu_dest_i, lsb_flag_i, lsb_val_i,
                             lsb_dest_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue. Allocates tags at issue, takes ALU/LSB
// result broadcasts, answers operand queries and retires one entry per cycle.
// Optional macro: ROB_QUERY_BYPASS_EN (see rob_query_port).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic            clockIn,
    input  logic            resetIn,
    reorder_buffer_if.slave rob_io
);
    localparam int unsigned        Depth     = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] CountFull = (ROB_WIDTH + 1)'(Depth);

    rob_entry_t           entries_q [Depth];
    rob_entry_t           entries_d [Depth];
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_flag_q, commit_flag_d;
    logic                 commit_store_q, commit_store_d;
    logic                 flush_flag_q, flush_flag_d;
    logic [REG_IDX_W-1:0] commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    rob_entry_t           head_entry;
    logic                 full_now;
    logic                 retire;
    logic                 flush_now;
    logic                 issue_fire;
    logic                 alu_wb;
    logic                 lsb_wb;

    logic [Depth-1:0]        busy_vec;
    logic [Depth-1:0]        ready_vec;
    logic [Depth-1:0][31:0]  val_vec;

    // Per-cycle control decisions derived from the current state.
    always_comb begin
        head_entry = entries_q[head_q];
        full_now   = (count_q == CountFull);
        retire     = rob_io.readyIn && head_entry.busy && head_entry.ready;
        flush_now  = retire && (head_entry.typ == ROB_BRANCH) &&
                     branch_mispredicted(head_entry.val[0], head_entry.pred_taken);
        issue_fire = rob_io.readyIn && rob_io.issueFlag && !full_now && !flush_now;
        // An entry allocated on this edge counts as busy for a same-edge broadcast.
        alu_wb     = rob_io.readyIn && rob_io.aluFlag &&
                     (entries_q[rob_io.aluDest].busy ||
                      (issue_fire && (rob_io.aluDest == tail_q)));
        lsb_wb     = rob_io.readyIn && rob_io.lsbFlag &&
                     (entries_q[rob_io.lsbDest].busy ||
                      (issue_fire && (rob_io.lsbDest == tail_q)));
    end

    // Next state: allocate, write back, retire, then flush overrides everything.
    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_flag_d  = rob_io.readyIn ? 1'b0 : commit_flag_q;
        commit_store_d = rob_io.readyIn ? 1'b0 : commit_store_q;
        flush_flag_d   = rob_io.readyIn ? 1'b0 : flush_flag_q;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_tag_d   = commit_tag_q;
        flush_pc_d     = flush_pc_q;

        if (issue_fire) begin
            entries_d[tail_q].busy       = 1'b1;
            entries_d[tail_q].ready      = 1'b0;
            entries_d[tail_q].typ        = rob_type_e'(rob_io.issueType);
            entries_d[tail_q].rd         = rob_io.issueRd;
            entries_d[tail_q].pred_taken = rob_io.issuePredTaken;
            entries_d[tail_q].alt_pc     = rob_io.issueAltPc;
            entries_d[tail_q].val        = '0;
            tail_d                       = tail_q + 1'b1;
        end

        if (alu_wb) begin
            entries_d[rob_io.aluDest].val   = rob_io.aluVal;
            entries_d[rob_io.aluDest].ready = 1'b1;
        end
        if (lsb_wb) begin
            entries_d[rob_io.lsbDest].val   = rob_io.lsbVal;
            entries_d[rob_io.lsbDest].ready = 1'b1;
        end

        if (retire) begin
            entries_d[head_q].busy  = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d                  = head_q + 1'b1;
            unique case (head_entry.typ)
                ROB_REG: begin
                    commit_flag_d = 1'b1;
                    commit_rd_d   = head_entry.rd;
                    commit_val_d  = head_entry.val;
                    commit_tag_d  = head_q;
                end
                ROB_STORE:  commit_store_d = 1'b1;
                ROB_BRANCH: begin
                    if (flush_now) begin
                        flush_flag_d = 1'b1;
                        flush_pc_d   = head_entry.alt_pc;
                    end
                end
                default: ;
            endcase
        end

        if (issue_fire && !retire) begin
            count_d = count_q + 1'b1;
        end else if (!issue_fire && retire) begin
            count_d = count_q - 1'b1;
        end

        if (flush_now) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State and registered outputs; readyIn low leaves every *_d equal to *_q.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_flag_q  <= 1'b0;
            commit_store_q <= 1'b0;
            flush_flag_q   <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_tag_q   <= '0;
            flush_pc_q     <= '0;
        end else begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_flag_q  <= commit_flag_d;
            commit_store_q <= commit_store_d;
            flush_flag_q   <= flush_flag_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_tag_q   <= commit_tag_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Flatten entry fields for the query ports.
    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            busy_vec[i]  = entries_q[i].busy;
            ready_vec[i] = entries_q[i].ready;
            val_vec[i]   = entries_q[i].val;
        end
    end

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_j (
        .tag_i      (rob_io.queryJ),
        .busy_i     (busy_vec),
        .ready_i    (ready_vec),
        .val_i      (val_vec),
        .alu_flag_i (rob_io.aluFlag),
        .alu_val_i  (rob_io.aluVal),
        .alu_dest_i (rob_io.aluDest),
        .lsb_flag_i (rob_io.lsbFlag),
        .lsb_val_i  (rob_io.lsbVal),
        .lsb_dest_i (rob_io.lsbDest),
        .ready_o    (rob_io.queryJReady),
        .val_o      (rob_io.queryJVal)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_k (
        .tag_i      (rob_io.queryK),
        .busy_i     (busy_vec),
        .ready_i    (ready_vec),
        .val_i      (val_vec),
        .alu_flag_i (rob_io.aluFlag),
        .alu_val_i  (rob_io.aluVal),
        .alu_dest_i (rob_io.aluDest),
        .lsb_flag_i (rob_io.lsbFlag),
        .lsb_val_i  (rob_io.lsbVal),
        .lsb_dest_i (rob_io.lsbDest),
        .ready_o    (rob_io.queryKReady),
        .val_o      (rob_io.queryKVal)
    );

    assign rob_io.issueTag    = tail_q;
    assign rob_io.full        = full_now;
    assign rob_io.commitFlag  = commit_flag_q;
    assign rob_io.commitRd    = commit_rd_q;
    assign rob_io.commitVal   = commit_val_q;
    assign rob_io.commitTag   = commit_tag_q;
    assign rob_io.commitStore = commit_store_q;
    assign rob_io.flushFlag   = flush_flag_q;
    assign rob_io.flushPc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table plus hand-written
// sequences; REG commits are checked against a scoreboard queue.
module tb_reorder_buffer;

    logic clk;
    logic resetIn;

    reorder_buffer_if #(.ROB_WIDTH(4)) bus ();

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn (clk),
        .resetIn (resetIn),
        .rob_io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
    } sb_item_t;

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] val;
        logic        use_lsb;
        logic [3:0]  exp_tag;
        logic        exp_commit;
        logic        exp_store;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NumVecs = 7;

    sb_item_t sb[$];
    sb_item_t mon_exp;
    vec_t     vecs [NumVecs];
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.issueFlag      = 1'b0;
        bus.issueType      = 2'd0;
        bus.issueRd        = 5'd0;
        bus.issuePredTaken = 1'b0;
        bus.issueAltPc     = 32'h0;
        bus.aluFlag        = 1'b0;
        bus.aluVal         = 32'h0;
        bus.aluDest        = 4'd0;
        bus.lsbFlag        = 1'b0;
        bus.lsbVal         = 32'h0;
        bus.lsbDest        = 4'd0;
    endtask

    task automatic issue(input logic [1:0] typ, input logic [4:0] rd, input logic pred,
                         input logic [31:0] alt);
        bus.issueFlag      = 1'b1;
        bus.issueType      = typ;
        bus.issueRd        = rd;
        bus.issuePredTaken = pred;
        bus.issueAltPc     = alt;
    endtask

    task automatic do_reset();
        clear_in();
        @(negedge clk);
        resetIn = 1'b0;
        #1;
        chk("rst_commit_flag", bus.commitFlag, 0);
        chk("rst_flush_flag", bus.flushFlag, 0);
        chk("rst_issue_tag", bus.issueTag, 0);
        @(posedge clk);
        #1;
        resetIn = 1'b1;
    endtask

    // Scoreboard monitor: every REG commit must match the oldest expectation.
    always @(negedge clk) begin
        if (resetIn && bus.commitFlag) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                chk("commit_rd", bus.commitRd, mon_exp.rd);
                chk("commit_val", bus.commitVal, mon_exp.val);
                chk("commit_tag", bus.commitTag, mon_exp.tag);
            end
        end
    end

    initial begin
        // typ, rd, pred, val, use_lsb, exp_tag, exp_commit, exp_store, exp_flush, exp_pc
        vecs[0] = '{2'd0, 5'd5,  1'b0, 32'h0000_1234, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{2'd0, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{2'd2, 5'd0,  1'b0, 32'h0000_0000, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{2'd0, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{2'd1, 5'd0,  1'b1, 32'h0000_0001, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{2'd1, 5'd0,  1'b0, 32'h0000_0002, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{2'd1, 5'd0,  1'b1, 32'h0000_0000, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 32'h106};

        resetIn     = 1'b0;
        bus.readyIn = 1'b1;
        bus.queryJ  = 4'd0;
        bus.queryK  = 4'd0;
        clear_in();
        #2;
        chk("init_commit_flag", bus.commitFlag, 0);
        chk("init_commit_store", bus.commitStore, 0);
        chk("init_flush_flag", bus.flushFlag, 0);
        chk("init_flush_pc", bus.flushPc, 0);
        chk("init_commit_val", bus.commitVal, 0);
        chk("init_full", bus.full, 0);
        chk("init_issue_tag", bus.issueTag, 0);
        next();
        resetIn = 1'b1;

        // Table: issue, broadcast, idle, then look at the retire outputs.
        for (int v = 0; v < NumVecs; v++) begin
            clear_in();
            issue(vecs[v].typ, vecs[v].rd, vecs[v].pred, 32'h100 + v);
            @(negedge clk);
            chk("vec_issue_tag", bus.issueTag, vecs[v].exp_tag);
            if (vecs[v].exp_commit) sb.push_back('{vecs[v].rd, vecs[v].val, vecs[v].exp_tag});
            next();
            clear_in();
            if (vecs[v].use_lsb) begin
                bus.lsbFlag = 1'b1;
                bus.lsbDest = vecs[v].exp_tag;
                bus.lsbVal  = vecs[v].val;
            end else begin
                bus.aluFlag = 1'b1;
                bus.aluDest = vecs[v].exp_tag;
                bus.aluVal  = vecs[v].val;
            end
            next();
            clear_in();
            next();
            @(negedge clk);
            chk("vec_commit_flag", bus.commitFlag, vecs[v].exp_commit);
            chk("vec_commit_store", bus.commitStore, vecs[v].exp_store);
            chk("vec_flush_flag", bus.flushFlag, vecs[v].exp_flush);
            if (vecs[v].exp_flush) begin
                chk("vec_flush_pc", bus.flushPc, vecs[v].exp_pc);
                chk("vec_flush_tail", bus.issueTag, 0);
            end
            next();
        end

        // Fill to 16 entries, reject the 17th, then retire tag0 and wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            clear_in();
            issue(2'd0, 5'(i + 1), 1'b0, 32'h0);
            @(negedge clk);
            chk("fill_tag", bus.issueTag, 32'(i));
            chk("fill_full", bus.full, 0);
            if (i == 0) sb.push_back('{5'd1, 32'h55, 4'd0});
            next();
        end
        @(negedge clk);
        chk("full_at_16", bus.full, 1);
        issue(2'd0, 5'd17, 1'b0, 32'h0);
        next();
        @(negedge clk);
        chk("ovf_tail", bus.issueTag, 0);
        chk("ovf_full", bus.full, 1);
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd0;
        bus.aluVal  = 32'h55;
        next();
        clear_in();
        issue(2'd0, 5'd20, 1'b0, 32'h0);
        @(negedge clk);
        chk("full_before_retire", bus.full, 1);
        next();
        @(negedge clk);
        chk("full_dropped", bus.full, 0);
        chk("wrap_tag", bus.issueTag, 0);
        chk("wrap_commit", bus.commitFlag, 1);
        next();
        @(negedge clk);
        chk("full_rerise", bus.full, 1);
        chk("wrap_tail", bus.issueTag, 1);
        clear_in();

        // Out-of-order completion still retires in order, one per cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            issue(2'd0, 5'(10 + i), 1'b0, 32'h0);
            sb.push_back('{5'(10 + i), 32'h10 + 32'(i), 4'(i)});
            next();
        end
        clear_in();
        bus.lsbFlag = 1'b1;
        bus.lsbDest = 4'd2;
        bus.lsbVal  = 32'h12;
        next();
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd1;
        bus.aluVal  = 32'h11;
        @(negedge clk);
        chk("order_no_early", bus.commitFlag, 0);
        next();
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd0;
        bus.aluVal  = 32'h10;
        next();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            next();
            @(negedge clk);
            chk("order_pulse", bus.commitFlag, 1);
        end
        next();
        @(negedge clk);
        chk("order_done", bus.commitFlag, 0);

        // Mispredicted branch flushes younger entries; later broadcasts are ignored.
        do_reset();
        issue(2'd1, 5'd0, 1'b0, 32'h80);
        next();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0, 32'h0);
            next();
        end
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd0;
        bus.aluVal  = 32'h1;
        next();
        clear_in();
        issue(2'd0, 5'd9, 1'b0, 32'h0);
        next();
        clear_in();
        @(negedge clk);
        chk("flush_flag", bus.flushFlag, 1);
        chk("flush_pc", bus.flushPc, 32'h80);
        chk("flush_tail", bus.issueTag, 0);
        chk("flush_full", bus.full, 0);
        next();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd1;
        bus.aluVal  = 32'h5;
        bus.lsbFlag = 1'b1;
        bus.lsbDest = 4'd2;
        bus.lsbVal  = 32'h6;
        @(negedge clk);
        chk("flush_pulse", bus.flushFlag, 0);
        next();
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd3;
        bus.aluVal  = 32'h7;
        bus.queryJ  = 4'd1;
        next();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_flush_commit", bus.commitFlag, 0);
            chk("post_flush_query", bus.queryJReady, 0);
            next();
        end

        // Query in the issue cycle with a same-cycle broadcast to the new tag.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 5'd1, 1'b0, 32'h0);
            next();
        end
        issue(2'd0, 5'd4, 1'b0, 32'h0);
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd3;
        bus.aluVal  = 32'h7;
        bus.queryJ  = 4'd3;
        bus.queryK  = 4'd5;
        @(negedge clk);
`ifdef ROB_QUERY_BYPASS_EN
        chk("bypass_j_ready", bus.queryJReady, 1);
        chk("bypass_j_val", bus.queryJVal, 32'h7);
`else
        chk("nobypass_j_ready", bus.queryJReady, 0);
`endif
        chk("query_k_idle", bus.queryKReady, 0);
        next();
        clear_in();
        bus.queryK = 4'd1;
        @(negedge clk);
        chk("query_j_ready", bus.queryJReady, 1);
        chk("query_j_val", bus.queryJVal, 32'h7);
        chk("query_k_busy", bus.queryKReady, 0);
        bus.queryK = 4'd3;
        #1;
        chk("query_k_ready", bus.queryKReady, 1);
        chk("query_k_val", bus.queryKVal, 32'h7);
        bus.queryJ = 4'd0;
        bus.queryK = 4'd0;

        // readyIn low freezes a ready head; then reset mid-stream clears outputs.
        do_reset();
        issue(2'd0, 5'd7, 1'b0, 32'h0);
        sb.push_back('{5'd7, 32'h77, 4'd0});
        next();
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd0;
        bus.aluVal  = 32'h77;
        next();
        clear_in();
        bus.readyIn = 1'b0;
        issue(2'd0, 5'd8, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            next();
            @(negedge clk);
            chk("frozen_commit", bus.commitFlag, 0);
            chk("frozen_tail", bus.issueTag, 1);
        end
        clear_in();
        bus.readyIn = 1'b1;
        next();
        @(negedge clk);
        chk("thaw_commit", bus.commitFlag, 1);
        next();
        issue(2'd0, 5'd9, 1'b0, 32'h0);
        sb.push_back('{5'd9, 32'h99, 4'd1});
        next();
        clear_in();
        bus.aluFlag = 1'b1;
        bus.aluDest = 4'd1;
        bus.aluVal  = 32'h99;
        next();
        clear_in();
        next();
        @(negedge clk);
        chk("pre_reset_commit", bus.commitFlag, 1);
        #1;
        resetIn = 1'b0;
        #1;
        chk("async_rst_flag", bus.commitFlag, 0);
        chk("async_rst_val", bus.commitVal, 0);
        chk("async_rst_rd", bus.commitRd, 0);
        chk("async_rst_tail", bus.issueTag, 0);
        next();
        resetIn = 1'b1;
        next();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
